mem_io_responder: RTL

- Memory-side responder for the CPU's byte-wide bus (address, write-data, read-data, write-strobe). Serves the 128 KB RAM and the memory-mapped I/O window (addr[17:16]==2'b11).
- Generates io_buffer_full for the CPU. Buffers UART output bytes in a TX FIFO, supplies UART input bytes, maintains the cycle counter, and flags program stop.
- Sits between the cpu top and the board RAM/UART glue.

---
 rtl/mem_map_pkg.sv | 19 +
 rtl/io_tx_fifo.sv | 68 ++++++
 rtl/mem_io_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants for the CPU byte bus.
// IO_SEL selects the I/O window on addr[17:16]; the IO_* register offsets are decoded from
// addr[2:0] inside that window. RAM_BYTES is the size of the RAM behind the bus.
package mem_map_pkg;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [2:0]  IO_UART_ADDR = 3'h0;
  localparam logic [2:0]  IO_CLK_ADDR  = 3'h4;
  // Upper snapshot bytes of the cycle counter.
  localparam logic [2:0]  IO_CLK_B1    = 3'h5;
  localparam logic [2:0]  IO_CLK_B2    = 3'h6;
  localparam logic [2:0]  IO_CLK_B3    = 3'h7;
  localparam logic [31:0] RAM_BYTES    = 32'h20000;

  function automatic logic is_io_addr(input logic [31:0] addr);
    return addr[17:16] == IO_SEL;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous byte FIFO buffering UART output.
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   push, push_data       write request; ignored when full
//   pop                   read request; ignored when empty
//   pop_data              head entry, combinational from storage
//   count, count_next     current occupancy and occupancy after this edge
//   full, empty           occupancy flags
module io_tx_fifo #(
  parameter int unsigned DEPTH_LOG = 3,
  parameter int unsigned WIDTH     = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic [DEPTH_LOG:0]   count,
  output logic [DEPTH_LOG:0]   count_next,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DepthCnt = (DEPTH_LOG + 1)'(Depth);

  logic [WIDTH-1:0]     storage [Depth];
  logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = storage[rd_ptr_q];
  assign count    = count_q;
  assign count_next = count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly DEPTH_LOG bits wide so they wrap modulo depth for free.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are never visible because empty gates tx_valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) storage[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: 128 KB RAM plus the I/O window.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   rdy_in                    bus access accepted only when high
//   mem_a, mem_wr, mem_dout   address, write flag, write data from the CPU
//   mem_din                   read data, valid the cycle after the request
//   io_buffer_full            TX FIFO within FULL_MARGIN slots of full (registered)
//   tx_data, tx_valid, tx_ready  byte stream toward the UART transmitter
//   rx_data, rx_valid, rx_pop    byte from the UART receiver and its consume pulse
//   program_stop              sticky, set by a write to the clock register
module mem_io_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH_LOG   = 3,
  parameter int unsigned FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop
);

  localparam int unsigned TxDepth  = 1 << TX_DEPTH_LOG;
  localparam int unsigned RamWords = 1 << RAM_ADDR_WIDTH;
  localparam logic [TX_DEPTH_LOG:0] FullThresh = (TX_DEPTH_LOG + 1)'(TxDepth - FULL_MARGIN);

  logic [7:0]                ram [RamWords];
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      is_io;
  logic [2:0]                io_reg;
  logic                      ram_we;

  logic [7:0]  mem_din_q, mem_din_d;
  logic [31:0] cycle_q;
  logic [31:0] snapshot_q, snapshot_d;
  logic        rx_pop_q, rx_pop_d;
  logic        stop_q, stop_d;
  logic        full_flag_q;

  logic                    fifo_push;
  logic [7:0]              fifo_push_data;
  logic [TX_DEPTH_LOG:0]   fifo_count, fifo_count_next;
  logic                    fifo_full, fifo_empty;

  logic unused_bits;
  assign unused_bits = ^{mem_a[31:18], fifo_count, fifo_full};

  assign ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];
  assign is_io    = is_io_addr(mem_a);
  assign io_reg   = mem_a[2:0];
  assign ram_we   = rdy_in && mem_wr && !is_io;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
  end

  always_comb begin
    mem_din_d      = mem_din_q;
    snapshot_d     = snapshot_q;
    rx_pop_d       = 1'b0;
    stop_d         = stop_q;
    fifo_push      = 1'b0;
    fifo_push_data = mem_dout;
    if (rdy_in) begin
      if (!mem_wr) begin
        if (!is_io) begin
          mem_din_d = ram[ram_addr];
        end else begin
          unique case (io_reg)
            IO_UART_ADDR: begin
              mem_din_d = rx_valid ? rx_data : 8'h00;
              rx_pop_d  = rx_valid;
            end
            // Snapshot the whole counter so the upper bytes read later form one coherent value.
            IO_CLK_ADDR: begin
              snapshot_d = cycle_q;
              mem_din_d  = cycle_q[7:0];
            end
            IO_CLK_B1: mem_din_d = snapshot_q[15:8];
            IO_CLK_B2: mem_din_d = snapshot_q[23:16];
            IO_CLK_B3: mem_din_d = snapshot_q[31:24];
            default:   mem_din_d = 8'h00;
          endcase
        end
      end else if (is_io) begin
        if (io_reg == IO_UART_ADDR) begin
          // 0x00 is reserved as the stop marker on the TX stream.
          fifo_push = (mem_dout != 8'h00);
        end else if (io_reg == IO_CLK_ADDR) begin
          fifo_push      = 1'b1;
          fifo_push_data = 8'h00;
          stop_d         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din_q   <= 8'h00;
      cycle_q     <= 32'h0;
      snapshot_q  <= 32'h0;
      rx_pop_q    <= 1'b0;
      stop_q      <= 1'b0;
      full_flag_q <= 1'b0;
    end else begin
      mem_din_q   <= mem_din_d;
      cycle_q     <= cycle_q + 32'h1;
      snapshot_q  <= snapshot_d;
      rx_pop_q    <= rx_pop_d;
      stop_q      <= stop_d;
      // Early warning: leaves room for CPU stores already in flight when the flag rises.
      full_flag_q <= (fifo_count_next >= FullThresh);
    end
  end

  io_tx_fifo #(
    .DEPTH_LOG (TX_DEPTH_LOG),
    .WIDTH     (8)
  ) u_tx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (fifo_push),
    .push_data  (fifo_push_data),
    .pop        (tx_ready),
    .pop_data   (tx_data),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign mem_din        = mem_din_q;
  assign rx_pop         = rx_pop_q;
  assign program_stop   = stop_q;
  assign io_buffer_full = full_flag_q;
  assign tx_valid       = !fifo_empty;

endmodule
